// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, one-bubble stall,
// branch flush, memory hold and a saturating load-use bubble counter.
module id_ex_stage #(
   parameter int XLEN      = 32,
   parameter int RS_WIDTH  = 5,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_id,
   input  logic [RS_WIDTH-1:0]  rs1_id,
   input  logic [RS_WIDTH-1:0]  rs2_id,
   input  logic [RS_WIDTH-1:0]  rd_id,
   input  logic [XLEN-1:0]      rs1_data_id,
   input  logic [XLEN-1:0]      rs2_data_id,
   input  logic [XLEN-1:0]      imm_id,
   input  logic [XLEN-1:0]      pc_id,
   input  logic                 regwrite_id,
   input  logic                 memread_id,
   input  logic                 memwrite_id,
   input  logic [3:0]           aluop_id,
   input  logic                 flush_ex,
   input  logic                 hold_mem,
   output logic                 valid_ex,
   output logic [RS_WIDTH-1:0]  rs1_ex,
   output logic [RS_WIDTH-1:0]  rs2_ex,
   output logic [RS_WIDTH-1:0]  rd_ex,
   output logic [XLEN-1:0]      rs1_data_ex,
   output logic [XLEN-1:0]      rs2_data_ex,
   output logic [XLEN-1:0]      imm_ex,
   output logic [XLEN-1:0]      pc_ex,
   output logic                 regwrite_ex,
   output logic                 memread_ex,
   output logic                 memwrite_ex,
   output logic [3:0]           aluop_ex,
   output logic                 stall_id,
   output logic [CNT_WIDTH-1:0] bubble_cnt
);

   typedef struct packed {
      logic                valid;
      logic [RS_WIDTH-1:0] rs1;
      logic [RS_WIDTH-1:0] rs2;
      logic [RS_WIDTH-1:0] rd;
      logic [XLEN-1:0]     rs1_data;
      logic [XLEN-1:0]     rs2_data;
      logic [XLEN-1:0]     imm;
      logic [XLEN-1:0]     pc;
      logic                regwrite;
      logic                memread;
      logic                memwrite;
      logic [3:0]          aluop;
   } ex_pkt_t;

   ex_pkt_t              ex_q, ex_d, id_pkt;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 luh;

   assign luh = valid_id & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
                ((ex_q.rd == rs1_id) | (ex_q.rd == rs2_id));

   // Flush overrides the hazard, so a killed slot never stalls decode.
   assign stall_id = hold_mem | (luh & ~flush_ex);

   always_comb begin
      id_pkt          = '0;
      id_pkt.valid    = valid_id;
      id_pkt.rs1      = rs1_id;
      id_pkt.rs2      = rs2_id;
      id_pkt.rd       = rd_id;
      id_pkt.rs1_data = rs1_data_id;
      id_pkt.rs2_data = rs2_data_id;
      id_pkt.imm      = imm_id;
      id_pkt.pc       = pc_id;
      // Writes to x0 are dropped here so forwarding never sees them.
      id_pkt.regwrite = regwrite_id & valid_id & (rd_id != '0);
      id_pkt.memread  = memread_id & valid_id;
      id_pkt.memwrite = memwrite_id & valid_id;
      id_pkt.aluop    = aluop_id;
   end

   always_comb begin
      ex_d  = ex_q;
      cnt_d = cnt_q;
      if (!hold_mem) begin
         if (flush_ex) begin
            ex_d = '0;
         end else if (luh) begin
            ex_d = '0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
         end else begin
            ex_d = id_pkt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   assign valid_ex    = ex_q.valid;
   assign rs1_ex      = ex_q.rs1;
   assign rs2_ex      = ex_q.rs2;
   assign rd_ex       = ex_q.rd;
   assign rs1_data_ex = ex_q.rs1_data;
   assign rs2_data_ex = ex_q.rs2_data;
   assign imm_ex      = ex_q.imm;
   assign pc_ex       = ex_q.pc;
   assign regwrite_ex = ex_q.regwrite;
   assign memread_ex  = ex_q.memread;
   assign memwrite_ex = ex_q.memwrite;
   assign aluop_ex    = ex_q.aluop;
   assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes model predictions, monitor
// pops and compares; a second instance with a 4-bit counter covers saturation.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm, pc;
      logic        rw, mr, mw;
      logic [3:0]  op;
      logic        flush, hold;
   } stim_t;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm, pc;
      logic        rw, mr, mw;
      logic [3:0]  op;
   } ex_t;

   typedef struct packed {
      logic        stall;
      ex_t         ex;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   stim_t s_in = '0;

   logic        valid_ex, regwrite_ex, memread_ex, memwrite_ex, stall_id;
   logic [4:0]  rs1_ex, rs2_ex, rd_ex;
   logic [31:0] rs1_data_ex, rs2_data_ex, imm_ex, pc_ex;
   logic [3:0]  aluop_ex;
   logic [15:0] bubble_cnt;

   logic        valid_b, regwrite_b, memread_b, memwrite_b, stall_b;
   logic [4:0]  rs1_b, rs2_b, rd_b;
   logic [31:0] d1_b, d2_b, imm_b, pc_b;
   logic [3:0]  aluop_b;
   logic [3:0]  cnt_b;

   int checks = 0;
   int errors = 0;

   exp_t sbq[$];
   ex_t  m_ex;
   logic [15:0] m_cnt;
   logic [3:0]  m_cnt4;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .RS_WIDTH(5), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .valid_id(s_in.valid),
      .rs1_id(s_in.rs1), .rs2_id(s_in.rs2), .rd_id(s_in.rd),
      .rs1_data_id(s_in.d1), .rs2_data_id(s_in.d2), .imm_id(s_in.imm), .pc_id(s_in.pc),
      .regwrite_id(s_in.rw), .memread_id(s_in.mr), .memwrite_id(s_in.mw), .aluop_id(s_in.op),
      .flush_ex(s_in.flush), .hold_mem(s_in.hold),
      .valid_ex(valid_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
      .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .pc_ex(pc_ex),
      .regwrite_ex(regwrite_ex), .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
      .aluop_ex(aluop_ex), .stall_id(stall_id), .bubble_cnt(bubble_cnt)
   );

   id_ex_stage #(.XLEN(32), .RS_WIDTH(5), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .valid_id(s_in.valid),
      .rs1_id(s_in.rs1), .rs2_id(s_in.rs2), .rd_id(s_in.rd),
      .rs1_data_id(s_in.d1), .rs2_data_id(s_in.d2), .imm_id(s_in.imm), .pc_id(s_in.pc),
      .regwrite_id(s_in.rw), .memread_id(s_in.mr), .memwrite_id(s_in.mw), .aluop_id(s_in.op),
      .flush_ex(s_in.flush), .hold_mem(s_in.hold),
      .valid_ex(valid_b), .rs1_ex(rs1_b), .rs2_ex(rs2_b), .rd_ex(rd_b),
      .rs1_data_ex(d1_b), .rs2_data_ex(d2_b), .imm_ex(imm_b), .pc_ex(pc_b),
      .regwrite_ex(regwrite_b), .memread_ex(memread_b), .memwrite_ex(memwrite_b),
      .aluop_ex(aluop_b), .stall_id(stall_b), .bubble_cnt(cnt_b)
   );

   ex_t act, act4;
   assign act  = {valid_ex, rs1_ex, rs2_ex, rd_ex, rs1_data_ex, rs2_data_ex, imm_ex, pc_ex,
                  regwrite_ex, memread_ex, memwrite_ex, aluop_ex};
   assign act4 = {valid_b, rs1_b, rs2_b, rd_b, d1_b, d2_b, imm_b, pc_b,
                  regwrite_b, memread_b, memwrite_b, aluop_b};

   task automatic chk(input string name, input logic [199:0] a, input logic [199:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
      end
   endtask

   // Reference: one rising edge applied to the abstract EX slot.
   task automatic drive_cycle(input stim_t s);
      exp_t e;
      logic hazard;
      s_in = s;
      hazard = s.valid && m_ex.valid && m_ex.mr && (m_ex.rd != 0) &&
               (m_ex.rd == s.rs1 || m_ex.rd == s.rs2);
      e.stall = s.hold || (hazard && !s.flush);
      if (!s.hold) begin
         if (s.flush) m_ex = '0;
         else if (hazard) begin
            m_ex = '0;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
         end else begin
            m_ex = '{valid: s.valid, rs1: s.rs1, rs2: s.rs2, rd: s.rd,
                     d1: s.d1, d2: s.d2, imm: s.imm, pc: s.pc,
                     rw: s.rw && s.valid && s.rd != 0,
                     mr: s.mr && s.valid, mw: s.mw && s.valid, op: s.op};
         end
      end
      e.ex = m_ex; e.cnt = m_cnt; e.cnt4 = m_cnt4;
      sbq.push_back(e);
      @(posedge clk); #2;
   endtask

   function automatic stim_t mk(input logic v, input int r1, input int r2, input int rd,
                                input logic mr, input logic rw, input logic fl, input logic hd);
      stim_t s;
      s.valid = v; s.rs1 = 5'(r1); s.rs2 = 5'(r2); s.rd = 5'(rd);
      s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom; s.pc = $urandom;
      s.rw = rw; s.mr = mr; s.mw = 1'($urandom); s.op = 4'($urandom);
      s.flush = fl; s.hold = hd;
      return s;
   endfunction

   function automatic stim_t rnd();
      stim_t s;
      s = mk($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 2) == 0, 1'($urandom),
             $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      return s;
   endfunction

   task automatic drain();
      for (int i = 0; i < 50 && sbq.size() > 0; i++) @(posedge clk);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ex"}, 200'(act), 200'(0));
      chk({tag, "_ex4"}, 200'(act4), 200'(0));
      chk({tag, "_cnt"}, 200'(bubble_cnt), 200'(0));
      chk({tag, "_cnt4"}, 200'(cnt_b), 200'(0));
      chk({tag, "_stall"}, 200'(stall_id), 200'(0));
   endtask

   // Monitor: stall is checked mid-cycle, EX state just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("stall_id", 200'(stall_id), 200'(e.stall));
            chk("stall_id4", 200'(stall_b), 200'(e.stall));
            @(posedge clk); #1;
            chk("ex_regs", 200'(act), 200'(e.ex));
            chk("ex_regs4", 200'(act4), 200'(e.ex));
            chk("bubble_cnt", 200'(bubble_cnt), 200'(e.cnt));
            chk("bubble_cnt4", 200'(cnt_b), 200'(e.cnt4));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      m_ex = '0; m_cnt = '0; m_cnt4 = '0;
      #3 chk_zero("reset0");
      @(posedge clk); #2 rst = 1'b1;

      // Load-use: lw x5 then add x6,x5,x7 (stall, then re-presented)
      drive_cycle(mk(1, 1, 2, 5, 1, 1, 0, 0));
      drive_cycle(mk(1, 5, 7, 6, 0, 1, 0, 0));
      drive_cycle(mk(1, 5, 7, 6, 0, 1, 0, 0));
      // lw x0 then use of x0, and rd=0 with regwrite
      drive_cycle(mk(1, 1, 2, 0, 1, 1, 0, 0));
      drive_cycle(mk(1, 0, 0, 0, 0, 1, 0, 0));
      // Flush together with load-use
      drive_cycle(mk(1, 1, 2, 5, 1, 1, 0, 0));
      drive_cycle(mk(1, 5, 3, 7, 0, 1, 1, 0));
      // Hold for 3 cycles with a flush inside, then release
      drive_cycle(mk(1, 1, 2, 3, 1, 1, 0, 0));
      drive_cycle(mk(1, 3, 4, 8, 0, 1, 0, 1));
      drive_cycle(mk(1, 9, 3, 8, 0, 1, 1, 1));
      drive_cycle(mk(0, 2, 2, 8, 0, 1, 0, 1));
      drive_cycle(mk(1, 3, 4, 8, 0, 1, 1, 0));
      // 17 load-use bubbles for saturation of the 4-bit counter
      for (int i = 0; i < 17; i++) begin
         drive_cycle(mk(1, 1, 2, 5, 1, 1, 0, 0));
         drive_cycle(mk(1, 4, 5, 6, 0, 1, 0, 0));
         drive_cycle(mk(1, 4, 5, 6, 0, 1, 0, 0));
      end
      drain();
      chk("sat_cnt4", 200'(cnt_b), 200'(4'hF));

      for (int i = 0; i < 1200; i++) drive_cycle(rnd());

      // Asynchronous reset mid-cycle with a valid instruction latched
      drive_cycle(mk(1, 1, 2, 9, 1, 1, 0, 0));
      drain();
      s_in = '0;
      #1 rst = 1'b0;
      #1 chk_zero("reset_mid");
      s_in.hold = 1'b1;
      #1 chk("reset_hold_stall", 200'(stall_id), 200'(1));
      s_in.hold = 1'b0;
      #1 rst = 1'b1;
      m_ex = '0; m_cnt = '0; m_cnt4 = '0;
      @(posedge clk); #2;
      drive_cycle(mk(1, 1, 2, 5, 1, 1, 0, 0));
      for (int i = 0; i < 300; i++) drive_cycle(rnd());
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection, sitting between the decode stage and the EX stage of the five-stage RISC-V pipeline. It captures decoded operands and control each cycle and presents the `rs1_ex`/`rs2_ex`/`*_ex` values consumed by EX-stage forwarding and the ALU. It stalls decode and injects a single bubble on a load-use dependency. It also obeys branch flush and memory hold requests, and keeps a saturating count of load-use bubbles for performance analysis.

## Interface

Parameters:
- XLEN, 32, datapath width
- RS_WIDTH, 5, register-index width
- CNT_WIDTH, 16, bubble counter width

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-low reset
- valid_id  input  1  decode stage holds a valid instruction
- rs1_id, rs2_id, rd_id  input  RS_WIDTH  decoded register indices
- rs1_data_id, rs2_data_id  input  XLEN  register-file read data
- imm_id, pc_id  input  XLEN  immediate, instruction PC
- regwrite_id, memread_id, memwrite_id  input  1  decoded control
- aluop_id  input  4  ALU operation code
- flush_ex  input  1  taken branch/jump resolved in EX; kill the instruction entering EX
- hold_mem  input  1  downstream memory stall; freeze this register
- valid_ex  output  1  EX holds a valid instruction
- rs1_ex, rs2_ex, rd_ex  output  RS_WIDTH  registered indices
- rs1_data_ex, rs2_data_ex, imm_ex, pc_ex  output  XLEN  registered data
- regwrite_ex, memread_ex, memwrite_ex  output  1  registered control
- aluop_ex  output  4  registered ALU op
- stall_id  output  1  combinational; IF/ID must hold its contents this cycle
- bubble_cnt  output  CNT_WIDTH  load-use bubbles inserted since reset

## Operation

- Load-use hazard, combinational: `luh = valid_id & valid_ex & memread_ex & (rd_ex != 0) & (rd_ex == rs1_id | rd_ex == rs2_id)`.
- Each rising edge, exactly one action applies, in priority order:
  1. **hold_mem = 1**: all registered outputs keep their values. `stall_id = 1`.
  2. **flush_ex = 1**: load a bubble. `stall_id = 0`. Upstream flushes IF/ID itself.
  3. **luh = 1**: load a bubble. `stall_id = 1`. `bubble_cnt` increments.
  4. **Otherwise**: load the ID inputs. `stall_id = 0`.
- `stall_id` is 1 only in cases 1 and 3. In all other cases it is 0.
- A bubble clears to 0: `valid_ex`, all control outputs, `aluop_ex`, all indices and all data outputs.
- Normal load:
  - `valid_ex <= valid_id`.
  - `regwrite_ex <= regwrite_id & valid_id & (rd_id != 0)`. This means a write to x0 never reaches forwarding.
  - `memread_ex` and `memwrite_ex` are ANDed with `valid_id`.
  - All other fields are copied directly.
- `bubble_cnt` saturates at all-ones. It does not count flush bubbles or hold cycles.
- A load-use stall lasts exactly one cycle. The bubble clears `memread_ex`, so `luh` deasserts on the next cycle and the stalled instruction enters EX.

## Timing

- Capture latency is 1 cycle: ID inputs sampled at edge N appear on the `*_ex` outputs after edge N.
- `stall_id` depends combinationally on the ID inputs, the registered EX outputs and `hold_mem`. It has no path from `flush_ex`, except that `flush_ex` overrides `luh` so `stall_id` reads 0 when both are asserted.
- Reset (`rst = 0`, asynchronous): every registered output and `bubble_cnt` go to 0 immediately, so `stall_id = 0` unless `hold_mem = 1`.
  - Release is synchronous to the next rising edge. The first capture occurs on the first edge with `rst = 1`.
  - Reset asserted during a stall or hold discards all state. No partial update occurs.
- Simultaneous events:
  - `hold_mem` wins over `flush_ex`. The requester must keep `flush_ex` asserted until `hold_mem` drops.
  - `flush_ex` wins over `luh`. No count is taken.
- `luh` with `valid_id = 0`: no stall and no bubble count.

## Test plan

- **Reset.** Assert `rst = 0` mid-cycle with a valid instruction latched → all outputs 0 asynchronously, `bubble_cnt = 0`. Release → the instruction presented on the next edge appears in EX one cycle later.
- **Load-use.**
  - Setup: EX holds `lw x5` (`memread_ex = 1`, `rd_ex = 5`). ID presents `add x6, x5, x7`.
  - Cycle N: `stall_id = 1`.
  - After edge N: bubble in EX (`valid_ex = 0`), `bubble_cnt = 1`.
  - Cycle N+1: `stall_id = 0`.
  - After edge N+1: `rs1_ex = 5`, `rd_ex = 6`, `valid_ex = 1`.
- **x0 and no-dependency cases.**
  - `lw x0` followed by a use of x0 → no stall.
  - An instruction with `rd_id = 0` and `regwrite_id = 1` → `regwrite_ex = 0`.
- **Flush versus load-use.** Assert `flush_ex` and a load-use condition in the same cycle → bubble, `stall_id = 0`, `bubble_cnt` unchanged.
- **Hold.**
  - Assert `hold_mem` for 3 cycles with changing ID inputs → EX outputs frozen and `stall_id = 1` throughout.
  - Assert `flush_ex` during the hold → no effect until `hold_mem` drops.
- **Saturation.** With `CNT_WIDTH = 4`, generate 17 load-use bubbles → `bubble_cnt` stays at 15.
